// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multi-cycle control unit.
// Models a word-addressed 16-bit RAM with WAIT_CYCLES wait states and returns
// registered read data plus a one-cycle MemReady pulse per completed access.
// Optional feature: define MEM_PROTECT_EN to block writes to word indices
// below PROT_TOP (the access still completes and ReqErr pulses with MemReady).
// ADDR_W is expected to be below 16 (the upper address bits are ignored).
module mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] PROT_TOP    = 16'h0040
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemR,
    input  logic        MemW,
    input  logic        IoD,
    input  logic [15:0] PC,
    input  logic [15:0] ALUOut,
    input  logic [15:0] WriteData,
    output logic [15:0] MemData,
    output logic        MemReady,
    output logic        Busy,
    output logic        ReqErr
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

`ifdef MEM_PROTECT_EN
    localparam bit PROTECT_EN = 1'b1;
`else
    localparam bit PROTECT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                op_write_q;
    logic [DATA_W-1:0]   ram [DEPTH];

    logic                req_c;
    logic                both_c;
    logic [ADDR_W-1:0]   req_idx_c;
    logic                strobe_held_c;
    logic                enter_done_c;
    logic [ADDR_W-1:0]   acc_addr_c;
    logic [DATA_W-1:0]   acc_data_c;
    logic                acc_write_c;
    logic                prot_c;
    logic                ram_we_c;
    logic                unused_addr_bits_c;

    // Upper address bits are intentionally dropped (addresses wrap).
    assign unused_addr_bits_c = ^{PC[DATA_W-1:ADDR_W], ALUOut[DATA_W-1:ADDR_W]};

    // Request decode and selection of the access that completes on this edge.
    always_comb begin
        req_c         = MemR ^ MemW;
        both_c        = MemR & MemW;
        req_idx_c     = IoD ? ALUOut[ADDR_W-1:0] : PC[ADDR_W-1:0];
        strobe_held_c = op_write_q ? MemW : MemR;
        enter_done_c  = 1'b0;
        acc_addr_c    = addr_q;
        acc_data_c    = wdata_q;
        acc_write_c   = op_write_q;
        case (state)
            S_IDLE: begin
                // Zero wait states: the live request completes on its accept edge.
                if (req_c && (WAIT_CYCLES == 0)) begin
                    enter_done_c = 1'b1;
                    acc_addr_c   = req_idx_c;
                    acc_data_c   = WriteData;
                    acc_write_c  = MemW;
                end
            end
            S_WAIT: begin
                if (strobe_held_c && (wait_cnt == CNT_W'(1))) begin
                    enter_done_c = 1'b1;
                end
            end
            default: begin
                enter_done_c = 1'b0;
            end
        endcase
        prot_c   = PROTECT_EN && acc_write_c && (DATA_W'(acc_addr_c) < PROT_TOP);
        ram_we_c = enter_done_c && acc_write_c && !prot_c;
    end

    // Control FSM with registered handshake outputs and read data.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            MemData    <= '0;
            MemReady   <= 1'b0;
            Busy       <= 1'b0;
            ReqErr     <= 1'b0;
        end else begin
            MemReady <= 1'b0;
            ReqErr   <= 1'b0;
            case (state)
                S_IDLE: begin
                    Busy <= 1'b0;
                    if (both_c) begin
                        ReqErr <= 1'b1;
                    end else if (req_c) begin
                        addr_q     <= req_idx_c;
                        wdata_q    <= WriteData;
                        op_write_q <= MemW;
                        wait_cnt   <= WAIT_LOAD;
                        Busy       <= 1'b1;
                        if (enter_done_c) begin
                            state    <= S_DONE;
                            MemReady <= 1'b1;
                            ReqErr   <= prot_c;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!strobe_held_c) begin
                        state    <= S_IDLE;
                        Busy     <= 1'b0;
                        wait_cnt <= '0;
                    end else if (enter_done_c) begin
                        state    <= S_DONE;
                        MemReady <= 1'b1;
                        ReqErr   <= prot_c;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
            if (enter_done_c && !acc_write_c) begin
                MemData <= ram[acc_addr_c];
            end
        end
    end

    // RAM array; contents survive Reset.
    always_ff @(posedge CLK) begin
        if (ram_we_c) begin
            ram[acc_addr_c] <= acc_data_c;
        end
    end

endmodule
